// File: rtl/aesl_deadlock_persist_monitor.sv
// Deadlock monitor for one HLS instance in the co-sim bench.
// A masked AXIS stall or a sub-instance block is flagged only after it
// persists PERSIST consecutive cycles, and never while every instance is idle.
module aesl_deadlock_persist_monitor #(
    parameter int unsigned          N_AXIS    = 4,
    parameter logic [N_AXIS-1:0]    AXIS_MASK = 4'b0110,
    parameter int unsigned          N_IDLE    = 4,
    parameter int unsigned          N_SUB     = 1,
    parameter int unsigned          SUB_ALL   = 1,
    parameter int unsigned          PERSIST   = 4,
    parameter int unsigned          STICKY    = 0,
    parameter int unsigned          CNT_W     = 8,
    localparam int unsigned         IDX_W     = (N_AXIS > 1) ? $clog2(N_AXIS) : 1,
    localparam int unsigned         RUN_W     = $clog2(PERSIST + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_AXIS-1:0]   axis_block_sigs,
    input  logic [N_IDLE-1:0]   inst_idle_sigs,
    input  logic [N_SUB-1:0]    inst_block_sigs,
    input  logic                clear,
    output logic                block,
    output logic                block_sticky,
    output logic [1:0]          block_src,
    output logic [IDX_W-1:0]    first_axis_idx,
    output logic [CNT_W-1:0]    event_cnt
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_PEND  = 2'd1,
        S_BLOCK = 2'd2
    } state_t;

    localparam logic [RUN_W-1:0] PERSIST_R = RUN_W'(PERSIST);

    state_t             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               block_q, block_d;
    logic               sticky_q, sticky_d;
    logic [1:0]         src_q, src_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_AXIS-1:0]  masked;
    logic               axis_hit;
    logic               sub_hit;
    logic               all_idle;
    logic               raw;
    logic [IDX_W-1:0]   low_idx;
    logic               found;
    logic               enter_block;
    logic [CNT_W-1:0]   cnt_base;

    // Raw block condition and lowest masked stalled channel.
    always_comb begin
        masked   = axis_block_sigs & AXIS_MASK;
        axis_hit = |masked;
        sub_hit  = (SUB_ALL != 0) ? &inst_block_sigs : |inst_block_sigs;
        all_idle = &inst_idle_sigs;
        raw      = (axis_hit | sub_hit) & ~all_idle;
        low_idx  = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N_AXIS; i++) begin
            if (masked[i] && !found) begin
                low_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

    // Next-state logic; clear is applied first so captures on the same edge win.
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        sticky_d    = sticky_q;
        src_d       = src_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        enter_block = 1'b0;
        if (clear) begin
            sticky_d = 1'b0;
            idx_d    = '0;
            cnt_d    = '0;
            src_d    = '0;
        end
        cnt_base = cnt_d;
        case (state_q)
            S_CLEAR: begin
                if (raw) begin
                    run_d = RUN_W'(1);
                    idx_d = low_idx;
                    if (PERSIST == 1) enter_block = 1'b1;
                    else              state_d     = S_PEND;
                end
            end
            S_PEND: begin
                if (!raw) begin
                    state_d = S_CLEAR;
                    run_d   = '0;
                end else begin
                    if (run_q != PERSIST_R) run_d = run_q + 1'b1;
                    if (run_q + 1'b1 == PERSIST_R) enter_block = 1'b1;
                end
            end
            S_BLOCK: begin
                if (STICKY != 0) begin
                    if (clear) begin
                        state_d = S_CLEAR;
                        run_d   = '0;
                    end
                end else if (!raw) begin
                    state_d = S_CLEAR;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                run_d   = '0;
            end
        endcase
        if (enter_block) begin
            state_d  = S_BLOCK;
            src_d    = {sub_hit, axis_hit};
            sticky_d = 1'b1;
            cnt_d    = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
        end
        block_d = (state_d == S_BLOCK);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_CLEAR;
            run_q    <= '0;
            block_q  <= 1'b0;
            sticky_q <= 1'b0;
            src_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            block_q  <= block_d;
            sticky_q <= sticky_d;
            src_q    <= src_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    assign block          = block_q;
    assign block_sticky   = sticky_q;
    assign block_src      = src_q;
    assign first_axis_idx = idx_q;
    assign event_cnt      = cnt_q;

endmodule

// File: tb/tb_aesl_deadlock_persist_monitor.sv
// Directed bench for the persistence deadlock monitor.
// Instance A: defaults; B: STICKY=1; C: CNT_W=2. All share the same inputs.
module tb_aesl_deadlock_persist_monitor;

    logic       clock;
    logic       reset;
    logic [3:0] axis;
    logic [3:0] idle;
    logic [0:0] sub;
    logic       clr;

    logic       a_blk, a_stk, b_blk, b_stk, c_blk, c_stk;
    logic [1:0] a_src, a_idx, b_src, b_idx, c_src, c_idx;
    logic [7:0] a_cnt, b_cnt;
    logic [1:0] c_cnt;

    int n_cmp = 0;
    int n_err = 0;

    aesl_deadlock_persist_monitor u_a (
        .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(sub), .clear(clr), .block(a_blk), .block_sticky(a_stk),
        .block_src(a_src), .first_axis_idx(a_idx), .event_cnt(a_cnt));

    aesl_deadlock_persist_monitor #(.STICKY(1)) u_b (
        .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(sub), .clear(clr), .block(b_blk), .block_sticky(b_stk),
        .block_src(b_src), .first_axis_idx(b_idx), .event_cnt(b_cnt));

    aesl_deadlock_persist_monitor #(.CNT_W(2)) u_c (
        .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(sub), .clear(clr), .block(c_blk), .block_sticky(c_stk),
        .block_src(c_src), .first_axis_idx(c_idx), .event_cnt(c_cnt));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] axis;
        logic [3:0] idle;
        logic       sub;
        logic       clr;
        logic       a_blk;
        logic       a_stk;
        logic [1:0] a_src;
        logic [1:0] a_idx;
        logic [7:0] a_cnt;
        logic       b_blk;
        logic       b_stk;
        logic [7:0] b_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] ax, input logic [3:0] id, input logic sb,
                                input logic cl, input logic ab, input logic as_,
                                input logic [1:0] asr, input logic [1:0] aix, input logic [7:0] ac,
                                input logic bb, input logic bs, input logic [7:0] bc);
        vec_t v;
        v.axis = ax;  v.idle = id;  v.sub = sb;  v.clr = cl;
        v.a_blk = ab; v.a_stk = as_; v.a_src = asr; v.a_idx = aix; v.a_cnt = ac;
        v.b_blk = bb; v.b_stk = bs; v.b_cnt = bc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after the edge.
    task automatic step(input logic [3:0] ax, input logic [3:0] id, input logic sb, input logic cl);
        @(negedge clock);
        axis = ax; idle = id; sub[0] = sb; clr = cl;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; axis = '0; idle = '0; sub = '0; clr = 1'b0;

        //         axis     idle   sb cl  ablk astk asrc aidx acnt  bblk bstk bcnt
        // PERSIST=4 stall on channel 2, then drop; B stays set until clear.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(4'b0100, 4'h0, 0, 0, 0, 0, 2'd0, 2'd2, 8'd0, 0, 0, 8'd0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(4'b0100, 4'h0, 0, 0, 1, 1, 2'd1, 2'd2, 8'd1, 1, 1, 8'd1));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 1, 2'd1, 2'd2, 8'd1, 1, 1, 8'd1));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 1, 0, 0, 2'd0, 2'd0, 8'd0, 0, 0, 8'd0));
        // Masked-off channels only.
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(4'b1001, 4'h0, 0, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, 0, 8'd0));
        // 3 high, 1 low, 3 high, 1 low: never reaches PERSIST.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++)
                vecs.push_back(mk(4'b0010, 4'h0, 0, 0, 0, 0, 2'd0, 2'd1, 8'd0, 0, 0, 8'd0));
            vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 0, 2'd0, 2'd1, 8'd0, 0, 0, 8'd0));
        end
        // All idle suppresses, one busy instance lets it flag.
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(4'b0100, 4'hF, 0, 0, 0, 0, 2'd0, 2'd1, 8'd0, 0, 0, 8'd0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(4'b0100, 4'hE, 0, 0, 0, 0, 2'd0, 2'd2, 8'd0, 0, 0, 8'd0));
        vecs.push_back(mk(4'b0100, 4'hE, 0, 0, 1, 1, 2'd1, 2'd2, 8'd1, 1, 1, 8'd1));
        vecs.push_back(mk(4'b0100, 4'hF, 0, 0, 0, 1, 2'd1, 2'd2, 8'd1, 1, 1, 8'd1));
        vecs.push_back(mk(4'b0100, 4'hF, 0, 1, 0, 0, 2'd0, 2'd0, 8'd0, 0, 0, 8'd0));
        // Sub-instance cause; later AXIS stall does not change captured source.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(4'b0000, 4'h0, 1, 0, 0, 0, 2'd0, 2'd0, 8'd0, 0, 0, 8'd0));
        vecs.push_back(mk(4'b0000, 4'h0, 1, 0, 1, 1, 2'd2, 2'd0, 8'd1, 1, 1, 8'd1));
        vecs.push_back(mk(4'b0010, 4'h0, 1, 0, 1, 1, 2'd2, 2'd0, 8'd1, 1, 1, 8'd1));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 1, 2'd2, 2'd0, 8'd1, 1, 1, 8'd1));
        // Clear and raw together in S_CLEAR: A starts PEND with capture; B leaves BLOCK.
        vecs.push_back(mk(4'b0100, 4'h0, 0, 1, 0, 0, 2'd0, 2'd2, 8'd0, 0, 0, 8'd0));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(4'b0100, 4'h0, 0, 0, 0, 0, 2'd0, 2'd2, 8'd0, 0, 0, 8'd0));
        vecs.push_back(mk(4'b0100, 4'h0, 0, 0, 1, 1, 2'd1, 2'd2, 8'd1, 0, 0, 8'd0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 1, 2'd1, 2'd2, 8'd1, 0, 0, 8'd0));

        // Reset state.
        #12;
        chk("rst_a_blk", a_blk, 0); chk("rst_a_stk", a_stk, 0);
        chk("rst_a_src", a_src, 0); chk("rst_a_idx", a_idx, 0);
        chk("rst_a_cnt", a_cnt, 0); chk("rst_b_blk", b_blk, 0);
        @(negedge clock);
        reset = 1'b1;

        foreach (vecs[k]) begin
            step(vecs[k].axis, vecs[k].idle, vecs[k].sub, vecs[k].clr);
            chk($sformatf("v%0d_a_blk", k), a_blk, vecs[k].a_blk);
            chk($sformatf("v%0d_a_stk", k), a_stk, vecs[k].a_stk);
            chk($sformatf("v%0d_a_src", k), a_src, vecs[k].a_src);
            chk($sformatf("v%0d_a_idx", k), a_idx, vecs[k].a_idx);
            chk($sformatf("v%0d_a_cnt", k), a_cnt, vecs[k].a_cnt);
            chk($sformatf("v%0d_b_blk", k), b_blk, vecs[k].b_blk);
            chk($sformatf("v%0d_b_stk", k), b_stk, vecs[k].b_stk);
            chk($sformatf("v%0d_b_cnt", k), b_cnt, vecs[k].b_cnt);
        end

        // Long masked-only stall after a clear.
        step(4'b0000, 4'h0, 0, 1);
        chk("clr_a_cnt", a_cnt, 0);
        chk("clr_c_cnt", c_cnt, 0);
        for (int i = 0; i < 20; i++) begin
            step(4'b1001, 4'h0, 0, 0);
            chk($sformatf("mask%0d_a_blk", i), a_blk, 0);
        end
        chk("mask_a_cnt", a_cnt, 0);

        // Five separate flag events: C saturates at 3, A keeps counting.
        for (int e = 1; e <= 5; e++) begin
            for (int i = 0; i < 4; i++) step(4'b0100, 4'h0, 0, 0);
            chk($sformatf("sat%0d_c_blk", e), c_blk, 1);
            chk($sformatf("sat%0d_c_cnt", e), c_cnt, (e > 3) ? 3 : e);
            chk($sformatf("sat%0d_a_cnt", e), a_cnt, e);
            step(4'b0000, 4'h0, 0, 0);
            chk($sformatf("sat%0d_c_drop", e), c_blk, 0);
        end

        // Asynchronous reset in the middle of BLOCK.
        for (int i = 0; i < 4; i++) step(4'b0100, 4'h0, 0, 0);
        chk("pre_rst_a_blk", a_blk, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_a_blk", a_blk, 0); chk("arst_a_stk", a_stk, 0);
        chk("arst_a_src", a_src, 0); chk("arst_a_idx", a_idx, 0);
        chk("arst_a_cnt", a_cnt, 0); chk("arst_b_blk", b_blk, 0);
        chk("arst_b_stk", b_stk, 0); chk("arst_b_src", b_src, 0);
        chk("arst_b_idx", b_idx, 0); chk("arst_b_cnt", b_cnt, 0);
        chk("arst_c_blk", c_blk, 0); chk("arst_c_stk", c_stk, 0);
        chk("arst_c_src", c_src, 0); chk("arst_c_idx", c_idx, 0);
        chk("arst_c_cnt", c_cnt, 0);
        @(negedge clock);
        axis = '0;
        reset = 1'b1;
        step(4'b0000, 4'h0, 0, 0);
        chk("post_rst_a_blk", a_blk, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
